// File: rtl/e203_ifu_bjp_prdt_pkg.sv
// Shared types and constants for the IFU lite branch predictor.
// Widths, register index constants, FSM encodings and the RAS depth default.
package e203_ifu_bjp_prdt_pkg;

    localparam int E203_PC_SIZE     = 32;
    localparam int E203_XLEN        = 32;
    localparam int E203_RFIDX_WIDTH = 5;

    localparam int RAS_DEPTH_DEFAULT = 2;

    localparam logic [E203_RFIDX_WIDTH-1:0] RFIDX_X0 = 5'd0;
    localparam logic [E203_RFIDX_WIDTH-1:0] RFIDX_X1 = 5'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RDRF = 2'd2
    } bpu_state_e;

endpackage

// File: rtl/e203_ifu_bpu_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
// Only instantiated when E203_BPU_RAS_EN is defined.
module e203_ifu_bpu_ras
    import e203_ifu_bjp_prdt_pkg::*;
#(
    parameter int DEPTH = RAS_DEPTH_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic [E203_PC_SIZE-1:0] push_data,
    input  logic                    pop,
    output logic [E203_PC_SIZE-1:0] top,
    output logic                    nonempty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [E203_PC_SIZE-1:0] stack [DEPTH];
    logic [PW-1:0]           ptr;
    logic [PW-1:0]           top_idx;
    logic [CW-1:0]           count;

    assign top_idx  = ptr - 1'b1;
    assign top      = stack[top_idx];
    assign nonempty = (count != '0);

    // Pop and push together replace the top in place: pointer and count stay put.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr   <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                stack[i] <= '0;
            end
        end else if (push && pop && nonempty) begin
            stack[top_idx] <= push_data;
        end else if (push) begin
            stack[ptr] <= push_data;
            ptr        <= ptr + 1'b1;
            if (count != CNT_FULL) begin
                count <= count + 1'b1;
            end
        end else if (pop && nonempty) begin
            ptr   <= ptr - 1'b1;
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/e203_ifu_bjp_prdt.sv
// IFU lite branch predictor: static taken prediction, next-PC adder operands, JALR rs1 sequencing.
// Optional return-address stack enabled by E203_BPU_RAS_EN.
//
// state   | meaning
// IDLE    | no rs1 read pending
// WAIT    | JALR xN blocked by a dependency or a busy read port
// RDRF    | regfile read port 1 returns rs1 this cycle
module e203_ifu_bjp_prdt
    import e203_ifu_bjp_prdt_pkg::*;
#(
    parameter int RAS_DEPTH = RAS_DEPTH_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [E203_PC_SIZE-1:0]     pc,
    input  logic                        dec_i_valid,
    input  logic                        dec_jal,
    input  logic                        dec_jalr,
    input  logic                        dec_bxx,
    input  logic                        dec_rv32,
    input  logic [E203_XLEN-1:0]        dec_bjp_imm,
    input  logic [E203_RFIDX_WIDTH-1:0] dec_jalr_rs1idx,
    input  logic                        dec_rd_link,
    input  logic                        oitf_empty,
    input  logic                        ir_empty,
    input  logic                        ir_rs1en,
    input  logic                        ir_rd_match_x1,
    input  logic                        ir_rd_match_rs1,
    input  logic [E203_XLEN-1:0]        rf2bpu_x1,
    input  logic [E203_XLEN-1:0]        rf2bpu_rs1,
    output logic                        bpu2rf_rs1_ena,
    output logic                        bpu_wait,
    output logic                        prdt_taken,
    output logic [E203_PC_SIZE-1:0]     prdt_pc_add_op1,
    output logic [E203_PC_SIZE-1:0]     prdt_pc_add_op2
);

    localparam logic [E203_PC_SIZE-1:0] PC_INC4 = 4;
    localparam logic [E203_PC_SIZE-1:0] PC_INC2 = 2;

    bpu_state_e state, state_nxt;

    logic rs1_x0, rs1_x1, rs1_xn;
    logic jalr_x1, jalr_xn;
    logic x1_dep, xn_dep, port_busy, xn_block;
    logic ras_hit;
    logic [E203_PC_SIZE-1:0] ras_top;
    logic [E203_PC_SIZE-1:0] inst_len;

    assign rs1_x0  = (dec_jalr_rs1idx == RFIDX_X0);
    assign rs1_x1  = (dec_jalr_rs1idx == RFIDX_X1);
    assign rs1_xn  = ~rs1_x0 & ~rs1_x1;
    assign jalr_x1 = dec_jalr & rs1_x1;
    assign jalr_xn = dec_jalr & rs1_xn;

    assign x1_dep    = jalr_x1 & (~oitf_empty | (~ir_empty & ir_rd_match_x1));
    assign xn_dep    = jalr_xn & (~oitf_empty | (~ir_empty & ir_rd_match_rs1));
    assign port_busy = ir_rs1en & ~ir_empty;
    assign xn_block  = xn_dep | port_busy;
    assign inst_len  = dec_rv32 ? PC_INC4 : PC_INC2;

`ifdef E203_BPU_RAS_EN
    logic ras_nonempty;
    logic ras_push, ras_pop;

    // A RAS hit replaces the x1 read, so it also removes the x1 dependency wait.
    assign ras_hit  = jalr_x1 & ras_nonempty;
    assign ras_pop  = dec_i_valid & ras_hit;
    assign ras_push = dec_i_valid & ~bpu_wait & (dec_jal | dec_jalr) & dec_rd_link;

    e203_ifu_bpu_ras #(
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ras_push),
        .push_data (pc + inst_len),
        .pop       (ras_pop),
        .top       (ras_top),
        .nonempty  (ras_nonempty)
    );
`else
    logic unused_no_ras;

    assign ras_hit       = 1'b0;
    assign ras_top       = '0;
    assign unused_no_ras = ^{dec_rd_link, RAS_DEPTH};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        bpu2rf_rs1_ena = 1'b0;
        case (state)
            ST_IDLE: begin
                if (dec_i_valid && jalr_xn) begin
                    if (xn_block) begin
                        state_nxt = ST_WAIT;
                    end else begin
                        bpu2rf_rs1_ena = 1'b1;
                        state_nxt      = ST_RDRF;
                    end
                end
            end
            ST_WAIT: begin
                // Losing valid here means fetch was flushed; drop the request.
                if (!(dec_i_valid && jalr_xn)) begin
                    state_nxt = ST_IDLE;
                end else if (!xn_block) begin
                    bpu2rf_rs1_ena = 1'b1;
                    state_nxt      = ST_RDRF;
                end
            end
            ST_RDRF: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign bpu_wait   = (x1_dep & ~ras_hit) | (jalr_xn & (state != ST_RDRF));
    assign prdt_taken = dec_jal | dec_jalr | (dec_bxx & dec_bjp_imm[E203_XLEN-1]);

    always_comb begin
        prdt_pc_add_op1 = pc;
        prdt_pc_add_op2 = inst_len;
        if (dec_bxx || dec_jal) begin
            prdt_pc_add_op2 = dec_bjp_imm[E203_PC_SIZE-1:0];
        end else if (dec_jalr) begin
            prdt_pc_add_op2 = dec_bjp_imm[E203_PC_SIZE-1:0];
            if (rs1_x0) begin
                prdt_pc_add_op1 = '0;
            end else if (rs1_x1) begin
                prdt_pc_add_op1 = ras_hit ? ras_top : rf2bpu_x1[E203_PC_SIZE-1:0];
            end else begin
                prdt_pc_add_op1 = rf2bpu_rs1[E203_PC_SIZE-1:0];
            end
        end
    end

endmodule

// File: tb/tb_e203_ifu_bjp_prdt.sv
// Directed self-checking bench for the IFU lite branch predictor.
// Exercises the RAS only when E203_BPU_RAS_EN is defined.
module tb_e203_ifu_bjp_prdt;
    import e203_ifu_bjp_prdt_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc;
    logic        dec_i_valid, dec_jal, dec_jalr, dec_bxx, dec_rv32;
    logic [31:0] dec_bjp_imm;
    logic [4:0]  dec_jalr_rs1idx;
    logic        dec_rd_link;
    logic        oitf_empty, ir_empty, ir_rs1en, ir_rd_match_x1, ir_rd_match_rs1;
    logic [31:0] rf2bpu_x1, rf2bpu_rs1;
    logic        bpu2rf_rs1_ena, bpu_wait, prdt_taken;
    logic [31:0] prdt_pc_add_op1, prdt_pc_add_op2;

    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [31:0] X1_VAL  = 32'h1111_0000;
    localparam logic [31:0] RS1_VAL = 32'h2222_0000;

    e203_ifu_bjp_prdt dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pc              (pc),
        .dec_i_valid     (dec_i_valid),
        .dec_jal         (dec_jal),
        .dec_jalr        (dec_jalr),
        .dec_bxx         (dec_bxx),
        .dec_rv32        (dec_rv32),
        .dec_bjp_imm     (dec_bjp_imm),
        .dec_jalr_rs1idx (dec_jalr_rs1idx),
        .dec_rd_link     (dec_rd_link),
        .oitf_empty      (oitf_empty),
        .ir_empty        (ir_empty),
        .ir_rs1en        (ir_rs1en),
        .ir_rd_match_x1  (ir_rd_match_x1),
        .ir_rd_match_rs1 (ir_rd_match_rs1),
        .rf2bpu_x1       (rf2bpu_x1),
        .rf2bpu_rs1      (rf2bpu_rs1),
        .bpu2rf_rs1_ena  (bpu2rf_rs1_ena),
        .bpu_wait        (bpu_wait),
        .prdt_taken      (prdt_taken),
        .prdt_pc_add_op1 (prdt_pc_add_op1),
        .prdt_pc_add_op2 (prdt_pc_add_op2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        pc = 32'h0; dec_i_valid = 1'b0; dec_jal = 1'b0; dec_jalr = 1'b0; dec_bxx = 1'b0;
        dec_rv32 = 1'b1; dec_bjp_imm = 32'h0; dec_jalr_rs1idx = 5'd0; dec_rd_link = 1'b0;
        oitf_empty = 1'b1; ir_empty = 1'b1; ir_rs1en = 1'b0;
        ir_rd_match_x1 = 1'b0; ir_rd_match_rs1 = 1'b0;
        rf2bpu_x1 = X1_VAL; rf2bpu_rs1 = RS1_VAL;
    endtask

    task automatic jalr_in(input logic [4:0] idx, input logic [31:0] imm);
        idle_in();
        dec_i_valid = 1'b1; dec_jalr = 1'b1; dec_jalr_rs1idx = idx; dec_bjp_imm = imm;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_in();
        #1;
        chk("rst_ena",  {31'd0, bpu2rf_rs1_ena}, 32'd0);
        chk("rst_wait", {31'd0, bpu_wait},       32'd0);
        chk("rst_op2",  prdt_pc_add_op2,         32'd4);
        #12 rst_n = 1'b1;
        tick();

        // backward branch
        idle_in(); dec_i_valid = 1'b1; dec_bxx = 1'b1; pc = 32'h100; dec_bjp_imm = 32'hFFFF_FFF0;
        #1;
        chk("bxx_bwd_taken", {31'd0, prdt_taken}, 32'd1);
        chk("bxx_bwd_op1",   prdt_pc_add_op1,     32'h100);
        chk("bxx_bwd_op2",   prdt_pc_add_op2,     32'hFFFF_FFF0);
        chk("bxx_bwd_wait",  {31'd0, bpu_wait},   32'd0);
        tick();

        dec_bjp_imm = 32'h20;
        #1;
        chk("bxx_fwd_taken", {31'd0, prdt_taken}, 32'd0);
        chk("bxx_fwd_op2",   prdt_pc_add_op2,     32'h20);
        dec_bxx = 1'b0; dec_jal = 1'b1;
        #1;
        chk("jal_taken", {31'd0, prdt_taken}, 32'd1);
        chk("jal_op1",   prdt_pc_add_op1,     32'h100);
        tick();

        // 16-bit non-bjp instruction
        idle_in(); dec_i_valid = 1'b1; dec_rv32 = 1'b0; pc = 32'hFFFF_FFFE;
        #1;
        chk("c16_taken", {31'd0, prdt_taken}, 32'd0);
        chk("c16_op1",   prdt_pc_add_op1,     32'hFFFF_FFFE);
        chk("c16_op2",   prdt_pc_add_op2,     32'd2);
        tick();

        jalr_in(5'd0, 32'h40);
        #1;
        chk("jalr_x0_op1",  prdt_pc_add_op1,   32'd0);
        chk("jalr_x0_op2",  prdt_pc_add_op2,   32'h40);
        chk("jalr_x0_wait", {31'd0, bpu_wait}, 32'd0);
        tick();

        // x1 dependency on an outstanding long-latency op
        jalr_in(5'd1, 32'h8); oitf_empty = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("x1dep_wait%0d", i), {31'd0, bpu_wait},       32'd1);
            chk($sformatf("x1dep_ena%0d", i),  {31'd0, bpu2rf_rs1_ena}, 32'd0);
            tick();
        end
        oitf_empty = 1'b1;
        #1;
        chk("x1_op1",  prdt_pc_add_op1,   X1_VAL);
        chk("x1_op2",  prdt_pc_add_op2,   32'h8);
        chk("x1_wait", {31'd0, bpu_wait}, 32'd0);
        ir_empty = 1'b0; ir_rd_match_x1 = 1'b1;
        #1;
        chk("x1_ir_wait", {31'd0, bpu_wait}, 32'd1);
        tick();

        // jalr x5 with read port busy for two cycles
        jalr_in(5'd5, 32'h10); ir_rs1en = 1'b1; ir_empty = 1'b0;
        #1;
        chk("xn_c0_wait", {31'd0, bpu_wait},       32'd1);
        chk("xn_c0_ena",  {31'd0, bpu2rf_rs1_ena}, 32'd0);
        tick();
        #1;
        chk("xn_c1_wait", {31'd0, bpu_wait},       32'd1);
        chk("xn_c1_ena",  {31'd0, bpu2rf_rs1_ena}, 32'd0);
        tick();
        ir_empty = 1'b1;
        #1;
        chk("xn_c2_wait", {31'd0, bpu_wait},       32'd1);
        chk("xn_c2_ena",  {31'd0, bpu2rf_rs1_ena}, 32'd1);
        tick();
        #1;
        chk("xn_rdrf_ena",  {31'd0, bpu2rf_rs1_ena}, 32'd0);
        chk("xn_rdrf_wait", {31'd0, bpu_wait},       32'd0);
        chk("xn_rdrf_op1",  prdt_pc_add_op1,         RS1_VAL);
        chk("xn_rdrf_op2",  prdt_pc_add_op2,         32'h10);
        tick();
        idle_in();
        #1;
        chk("xn_after_ena", {31'd0, bpu2rf_rs1_ena}, 32'd0);
        tick();

        // jalr x6 with nothing blocking: request straight from IDLE
        jalr_in(5'd6, 32'h4);
        #1;
        chk("xn_fast_ena",  {31'd0, bpu2rf_rs1_ena}, 32'd1);
        chk("xn_fast_wait", {31'd0, bpu_wait},       32'd1);
        tick();
        #1;
        chk("xn_fast_rdrf_wait", {31'd0, bpu_wait}, 32'd0);
        idle_in();
        tick();

        // flush while waiting
        jalr_in(5'd5, 32'h0); oitf_empty = 1'b0;
        tick();
        dec_i_valid = 1'b0; oitf_empty = 1'b1;
        #1;
        chk("flush_ena", {31'd0, bpu2rf_rs1_ena}, 32'd0);
        tick();
        #1;
        chk("flush_not_rdrf", {31'd0, bpu_wait}, 32'd1);
        idle_in();
        tick();

        // async reset while waiting
        jalr_in(5'd5, 32'h0); oitf_empty = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("rstw_ena",  {31'd0, bpu2rf_rs1_ena}, 32'd0);
        chk("rstw_wait", {31'd0, bpu_wait},       32'd1);
        idle_in();
        #1;
        chk("rstw_idle_wait", {31'd0, bpu_wait}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        jalr_in(5'd7, 32'h0);
        #1;
        chk("rstw_rel_ena", {31'd0, bpu2rf_rs1_ena}, 32'd1);
        tick();
        idle_in();
        tick();

`ifdef E203_BPU_RAS_EN
        idle_in(); dec_i_valid = 1'b1; dec_jal = 1'b1; dec_rd_link = 1'b1; pc = 32'h200;
        tick();
        jalr_in(5'd1, 32'h0); oitf_empty = 1'b0;
        #1;
        chk("ras_pop_wait", {31'd0, bpu_wait}, 32'd0);
        chk("ras_pop_op1",  prdt_pc_add_op1,   32'h204);
        tick();
        idle_in(); dec_i_valid = 1'b1; dec_jal = 1'b1; dec_rd_link = 1'b1; pc = 32'h300;
        tick();
        pc = 32'h400; dec_rv32 = 1'b0;
        tick();
        pc = 32'h500; dec_rv32 = 1'b1;
        tick();
        jalr_in(5'd1, 32'h0); oitf_empty = 1'b0;
        #1;
        chk("ras_full_top", prdt_pc_add_op1, 32'h504);
        tick();
        #1;
        chk("ras_full_next", prdt_pc_add_op1, 32'h402);
        chk("ras_full_wait", {31'd0, bpu_wait}, 32'd0);
        tick();
        #1;
        chk("ras_empty_wait", {31'd0, bpu_wait}, 32'd1);
        oitf_empty = 1'b1;
        #1;
        chk("ras_empty_op1", prdt_pc_add_op1, X1_VAL);
        idle_in();
        tick();
`else
        idle_in(); dec_i_valid = 1'b1; dec_jal = 1'b1; dec_rd_link = 1'b1; pc = 32'h200;
        tick();
        jalr_in(5'd1, 32'h0); oitf_empty = 1'b0;
        #1;
        chk("noras_wait", {31'd0, bpu_wait}, 32'd1);
        chk("noras_op1",  prdt_pc_add_op1,   X1_VAL);
        idle_in();
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/e203_ifu_bjp_prdt.md
Name: e203_ifu_bjp_prdt

Overview:
- Lite branch predictor in the IFU, directly downstream of the IFU mini-decoder.
- Consumes the mini-decoder's branch/jump info (jal/jalr/bxx, immediate, jalr rs1 index) for the instruction being fetched.
- Produces a static taken prediction and the two next-PC adder operands.
- Stalls fetch while a JALR rs1 operand is unavailable, and sequences a one-cycle regfile read for rs1 = xN.

Parameters:
- RAS_DEPTH, 2, return-address-stack entries; used only with E203_BPU_RAS_EN; power of 2, minimum 2.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- pc  in  E203_PC_SIZE  PC of the instruction being decoded
- dec_i_valid  in  1  mini-decoder output valid this cycle
- dec_jal  in  1  instruction is JAL
- dec_jalr  in  1  instruction is JALR
- dec_bxx  in  1  instruction is a conditional branch
- dec_rv32  in  1  1 = 32-bit instruction, 0 = 16-bit
- dec_bjp_imm  in  E203_XLEN  sign-extended branch/jump immediate
- dec_jalr_rs1idx  in  E203_RFIDX_WIDTH  JALR rs1 index
- dec_rd_link  in  1  rd is x1 or x5; used only with RAS
- oitf_empty  in  1  no long-latency instruction outstanding
- ir_empty  in  1  IR stage holds no valid instruction
- ir_rs1en  in  1  IR instruction uses the regfile read port 1
- ir_rd_match_x1  in  1  IR instruction writes x1
- ir_rd_match_rs1  in  1  IR instruction writes the JALR rs1 register
- rf2bpu_x1  in  E203_XLEN  dedicated x1 read value
- rf2bpu_rs1  in  E203_XLEN  regfile read port 1 data
- bpu2rf_rs1_ena  out  1  one-cycle request to latch dec_jalr_rs1idx onto read port 1
- bpu_wait  out  1  hold fetch; the prediction is not yet valid
- prdt_taken  out  1  predicted taken
- prdt_pc_add_op1  out  E203_PC_SIZE  next-PC adder operand 1
- prdt_pc_add_op2  out  E203_PC_SIZE  next-PC adder operand 2

Behaviour:
- Reset: FSM goes to IDLE. Read-request flop = 0. RAS pointer = 0 and count = 0. bpu2rf_rs1_ena = 0. bpu_wait = 0.
- Combinational outputs after reset follow their inputs.
- prdt_taken = dec_jal | dec_jalr | (dec_bxx & dec_bjp_imm[E203_XLEN-1]); backward branches are taken.
- Operands for bxx/jal: op1 = pc, op2 = imm.
- Operands for jalr, op2 = imm in all cases:
  - rs1 = x0: op1 = 0.
  - rs1 = x1: op1 = rf2bpu_x1.
  - otherwise: op1 = rf2bpu_rs1.
- Operands for a non-bjp instruction: op1 = pc, op2 = dec_rv32 ? 4 : 2.
- x1 dependency: jalr & rs1 == x1 & (~oitf_empty | (~ir_empty & ir_rd_match_x1)).
- xN dependency: jalr & rs1 ∉ {x0, x1} & (~oitf_empty | (~ir_empty & ir_rd_match_rs1)).
- FSM states:
  - IDLE: on dec_i_valid & jalr-xN with no xN dependency and (ir_empty | ~ir_rs1en), assert bpu2rf_rs1_ena and go to RDRF. If the xN dependency holds, or ir_rs1en & ~ir_empty, go to WAIT.
  - WAIT: stay while the dependency or port conflict persists. When both clear, assert bpu2rf_rs1_ena and go to RDRF.
  - RDRF: one cycle. rf2bpu_rs1 is valid in this cycle. Go to IDLE.
- bpu_wait = x1 dependency | (jalr-xN & state != RDRF); it deasserts in the RDRF cycle.
- The x1 path never uses the FSM.
- If dec_i_valid drops in WAIT, return to IDLE with no read request; fetch has been flushed.
- Asynchronous reset in any state returns to IDLE at once; no pending read is issued.
- All PC additions truncate to E203_PC_SIZE; wrap-around is allowed.

Optional Feature:
- E203_BPU_RAS_EN defined:
  - Push: on dec_i_valid & ~bpu_wait & (jal | jalr) & dec_rd_link, push pc + (dec_rv32 ? 4 : 2).
  - Full: a push overwrites the oldest entry (circular). The count saturates at RAS_DEPTH.
  - Pop: jalr with rs1 = x1 and count != 0 pops and predicts op1 = RAS top, op2 = imm, with no x1-dependency wait.
  - Simultaneous pop and push: pop first, then push into the freed slot.
  - Empty: fall back to the x1 path.
- Not defined: no RAS state, and dec_rd_link is ignored.

Decomposition:
- Shared package/defines: FSM state encodings (IDLE = 2'd0, WAIT = 2'd1, RDRF = 2'd2), register index constants for x0/x1, and the RAS_DEPTH default.
- Sub-module e203_ifu_bpu_ras: circular stack with push/pop/top/count. Instantiated only under E203_BPU_RAS_EN.

Test Plan:
- bxx, imm = 0xFFFF_FFF0, pc = 0x100 -> prdt_taken = 1, op1 = 0x100, op2 = 0xFFFF_FFF0, bpu_wait = 0.
- bxx, imm = 0x20 -> prdt_taken = 0; jal, imm = 0x20 -> prdt_taken = 1.
- jalr rs1 = x1, oitf_empty = 0 for 3 cycles -> bpu_wait = 1 for 3 cycles; then op1 = rf2bpu_x1 and bpu_wait = 0.
- jalr rs1 = x5, ir_rs1en = 1 and ir_empty = 0 for 2 cycles -> WAIT for 2 cycles, then bpu2rf_rs1_ena pulses for exactly 1 cycle; RDRF cycle gives op1 = rf2bpu_rs1 and bpu_wait = 0.
- rst_n low while in WAIT -> IDLE, bpu2rf_rs1_ena = 0, bpu_wait follows inputs.
- RAS: jal with rd_link at pc = 0x200, then jalr x1 with imm = 0 and oitf_empty = 0 -> op1 = 0x204, no wait. Three pushes into a 2-deep RAS -> the oldest entry is overwritten.
